// File: rtl/mc_pkg.sv
// Shared types and codes for the multicycle MIPS control unit (mc_ctrl).
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11,
        S_ERROR   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_ADDI  = 2'b11;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH  = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // States that stall on the memory handshake and are watched by the timer.
    function automatic logic is_wait_state(state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Counts consecutive not-ready cycles in a memory wait state and flags the
// cycle that would exceed TIMEOUT_MAX (TIMEOUT_MAX = 0 never flags).
module mc_wait_timer #(
    parameter int TIMEOUT_MAX = 15,
    parameter int TIMEOUT_W   = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic mem_ready,
    input  logic clear,
    output logic timeout_hit
);

    localparam logic [TIMEOUT_W-1:0] LIMIT = TIMEOUT_W'(TIMEOUT_MAX);

    logic [TIMEOUT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear)
            count <= '0;
        else if (active && !mem_ready)
            count <= count + TIMEOUT_W'(1);
    end

    assign timeout_hit = (TIMEOUT_MAX != 0) && active && !mem_ready && (count == LIMIT);

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle MIPS control FSM with memory handshake, wait timeout and
// illegal-opcode pulse. Define MC_BNE_EN to decode BNE (opcode 000101).
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int TIMEOUT_MAX = 15,
    parameter int TIMEOUT_W   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       branch,
    output logic       branch_ne,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic [1:0] pcsrc,
    output logic       illegal,
    output logic       mem_err,
    output logic [3:0] state
);

    state_t cur, nxt;
    logic   is_bne;
    logic   timeout_hit;

    mc_wait_timer #(
        .TIMEOUT_MAX(TIMEOUT_MAX),
        .TIMEOUT_W  (TIMEOUT_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .active     (is_wait_state(cur)),
        .mem_ready  (mem_ready),
        .clear      (nxt != cur),
        .timeout_hit(timeout_hit)
    );

    // mem_ready is checked before the timeout so a late ready still completes.
    always_comb begin
        nxt     = cur;
        illegal = 1'b0;
        case (cur)
            S_FETCH:   if (mem_ready) nxt = S_DECODE; else if (timeout_hit) nxt = S_ERROR;
            S_DECODE: begin
                case (op)
                    OP_RTYPE:      nxt = S_EXECUTE;
                    OP_LW, OP_SW:  nxt = S_MEMADR;
                    OP_BEQ:        nxt = S_BRANCH;
`ifdef MC_BNE_EN
                    OP_BNE:        nxt = S_BRANCH;
`endif
                    OP_ADDI:       nxt = S_ADDIEX;
                    OP_J:          nxt = S_JUMP;
                    default: begin
                        nxt     = S_FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR:  nxt = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   if (mem_ready) nxt = S_MEMWB; else if (timeout_hit) nxt = S_ERROR;
            S_MEMWR:   if (mem_ready) nxt = S_FETCH; else if (timeout_hit) nxt = S_ERROR;
            S_EXECUTE: nxt = S_ALUWB;
            S_ADDIEX:  nxt = S_ADDIWB;
            S_ERROR:   nxt = S_ERROR;
            default:   nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur    <= S_FETCH;
            is_bne <= 1'b0;
        end else begin
            cur <= nxt;
            if (cur == S_DECODE) begin
`ifdef MC_BNE_EN
                is_bne <= (op == OP_BNE);
`else
                is_bne <= 1'b0;
`endif
            end
        end
    end

    always_comb begin
        mem_req   = 1'b0;
        iord      = 1'b0;
        memwrite  = 1'b0;
        irwrite   = 1'b0;
        pcwrite   = 1'b0;
        branch    = 1'b0;
        branch_ne = 1'b0;
        regdst    = 1'b0;
        memtoreg  = 1'b0;
        regwrite  = 1'b0;
        alusrca   = 1'b0;
        alusrcb   = SRCB_RT;
        aluop     = ALUOP_ADD;
        pcsrc     = PCSRC_ALU;
        case (cur)
            S_FETCH: begin
                mem_req = 1'b1;
                alusrcb = SRCB_FOUR;
                irwrite = mem_ready;
                pcwrite = mem_ready;
            end
            S_DECODE:  alusrcb = SRCB_IMMSH;
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                mem_req  = 1'b1;
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = PCSRC_ALUOUT;
                branch  = ~is_bne;
`ifdef MC_BNE_EN
                branch_ne = is_bne;
`endif
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                aluop   = ALUOP_ADDI;
            end
            S_ADDIWB:  regwrite = 1'b1;
            S_JUMP: begin
                pcsrc   = PCSRC_JUMP;
                pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    assign mem_err = (cur == S_ERROR);
    assign state   = cur;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed scenarios plus random traffic
// against an instruction-level reference model (honours MC_BNE_EN).
module tb_mc_ctrl;

    localparam int TMAX = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op;
    logic       mem_ready;
    logic       mem_req, iord, memwrite, irwrite, pcwrite, branch, branch_ne;
    logic       regdst, memtoreg, regwrite, alusrca, illegal, mem_err;
    logic [1:0] alusrcb, aluop, pcsrc;
    logic [3:0] state;

    mc_ctrl #(.TIMEOUT_MAX(TMAX), .TIMEOUT_W(2)) dut (
        .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
        .mem_req(mem_req), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
        .pcwrite(pcwrite), .branch(branch), .branch_ne(branch_ne), .regdst(regdst),
        .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
        .aluop(aluop), .pcsrc(pcsrc), .illegal(illegal), .mem_err(mem_err), .state(state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // Reference model: current state plus the remaining state path of the
    // instruction in flight, derived from its opcode at fetch time.
    int m_state;
    int m_zeros;
    bit m_isbne;
    int m_rest[$];
    int mw_count;
    int cyc_count;

    function automatic bit op_legal(logic [5:0] o);
        case (o)
            6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010: return 1'b1;
`ifdef MC_BNE_EN
            6'b000101: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [17:0] exp_ctrl(int st, logic r, bit isbne);
        logic mq, io, mw, ir, pw, br, bn, rd, mt, rw, sa, me;
        logic [1:0] sb, ao, ps;
        {mq, io, mw, ir, pw, br, bn, rd, mt, rw, sa, me} = '0;
        sb = 2'b00; ao = 2'b00; ps = 2'b00;
        case (st)
            0:  begin mq = 1; sb = 2'b01; ir = r; pw = r; end
            1:  sb = 2'b11;
            2:  begin sa = 1; sb = 2'b10; end
            3:  begin mq = 1; io = 1; end
            4:  begin mt = 1; rw = 1; end
            5:  begin mq = 1; io = 1; mw = 1; end
            6:  begin sa = 1; ao = 2'b10; end
            7:  begin rd = 1; rw = 1; end
            8:  begin sa = 1; ao = 2'b01; ps = 2'b01; br = !isbne; bn = isbne; end
            9:  begin sa = 1; sb = 2'b10; ao = 2'b11; end
            10: rw = 1;
            11: begin ps = 2'b10; pw = 1; end
            12: me = 1;
            default: ;
        endcase
        return {mq, io, mw, ir, pw, br, bn, rd, mt, rw, sa, sb, ao, ps, me};
    endfunction

    task automatic model_step(input logic [5:0] o, input logic r, input logic rs);
        if (rs) begin
            m_state = 0; m_zeros = 0; m_isbne = 0; m_rest.delete();
            return;
        end
        if (m_state == 12) return;
        if ((m_state == 0 || m_state == 3 || m_state == 5) && !r) begin
            m_zeros++;
            if (m_zeros > TMAX) begin
                m_state = 12;
                m_zeros = 0;
            end
            return;
        end
        m_zeros = 0;
        if (m_state == 0) begin
            m_rest.delete();
            case (o)
                6'b000000: m_rest = '{6, 7};
                6'b100011: m_rest = '{2, 3, 4};
                6'b101011: m_rest = '{2, 5};
                6'b000100: m_rest = '{8};
`ifdef MC_BNE_EN
                6'b000101: m_rest = '{8};
`endif
                6'b001000: m_rest = '{9, 10};
                6'b000010: m_rest = '{11};
                default: ;
            endcase
            m_state = 1;
        end else begin
            if (m_state == 1) begin
`ifdef MC_BNE_EN
                m_isbne = (o == 6'b000101);
`else
                m_isbne = 1'b0;
`endif
            end
            m_state = (m_rest.size() > 0) ? m_rest.pop_front() : 0;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp)
        else begin
            fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h (model state %0d)", tag, act, exp, m_state);
        end
    endtask

    // Drive one cycle at the falling edge, compare, then advance the model.
    task automatic applyStimulus(input logic [5:0] o, input logic r, input logic rs);
        op = o; mem_ready = r; rst = rs;
        #1;
        checkOutput("state", 32'(state), 32'(m_state));
        checkOutput("ctrl", 32'({mem_req, iord, memwrite, irwrite, pcwrite, branch, branch_ne,
                                 regdst, memtoreg, regwrite, alusrca, alusrcb, aluop, pcsrc,
                                 mem_err}), 32'(exp_ctrl(m_state, r, m_isbne)));
        checkOutput("illegal", 32'(illegal), 32'((m_state == 1) && !op_legal(o)));
        if (memwrite === 1'b1) mw_count++;
        cyc_count++;
        @(posedge clk);
        model_step(o, r, rs);
        @(negedge clk);
    endtask

    task automatic runInstr(input logic [5:0] o);
        int n = 0;
        applyStimulus(o, 1'b1, 1'b0);
        while (m_state != 0 && n < 20) begin
            applyStimulus(o, 1'b1, 1'b0);
            n++;
        end
    endtask

    initial begin
        logic [5:0] cur_op;
        rst = 1'b1; op = 6'b0; mem_ready = 1'b0;
        m_state = 0; m_zeros = 0; m_isbne = 0; mw_count = 0; cyc_count = 0;
        @(posedge clk);
        @(negedge clk);

        applyStimulus(6'b000000, 1'b0, 1'b1);
        applyStimulus(6'b000000, 1'b1, 1'b1);

        runInstr(6'b100011);

        // SW with three not-ready cycles in MEMWR
        mw_count = 0; cyc_count = 0;
        applyStimulus(6'b101011, 1'b1, 1'b0);
        applyStimulus(6'b101011, 1'b1, 1'b0);
        applyStimulus(6'b101011, 1'b1, 1'b0);
        repeat (3) applyStimulus(6'b101011, 1'b0, 1'b0);
        applyStimulus(6'b101011, 1'b1, 1'b0);
        checkOutput("sw_memwrite_cycles", 32'(mw_count), 32'd4);
        checkOutput("sw_total_cycles", 32'(cyc_count), 32'd7);

        runInstr(6'b000100);
        runInstr(6'b000101);
        runInstr(6'b111111);
        runInstr(6'b000000);
        runInstr(6'b001000);
        runInstr(6'b000010);

        // Timeout in FETCH, sticky error, then recovery by reset
        repeat (4) applyStimulus(6'b000000, 1'b0, 1'b0);
        repeat (3) applyStimulus(6'b000000, 1'b1, 1'b0);
        applyStimulus(6'b000000, 1'b0, 1'b1);
        checkOutput("fetch_after_error_reset", 32'(state), 32'd0);

        // Ready arrives exactly on the timeout-hit cycle
        repeat (3) applyStimulus(6'b000000, 1'b0, 1'b0);
        applyStimulus(6'b000000, 1'b1, 1'b0);
        runInstr(6'b000000);

        // Reset while LW is in MEMRD
        repeat (3) applyStimulus(6'b100011, 1'b1, 1'b0);
        applyStimulus(6'b100011, 1'b0, 1'b1);
        runInstr(6'b001000);

        cur_op = 6'b000000;
        for (int i = 0; i < 400; i++) begin
            if (m_state == 12) begin
                applyStimulus(cur_op, 1'b1, 1'b1);
            end else begin
                if (m_state == 0) begin
                    case ($urandom_range(0, 8))
                        0: cur_op = 6'b000000;
                        1: cur_op = 6'b100011;
                        2: cur_op = 6'b101011;
                        3: cur_op = 6'b000100;
                        4: cur_op = 6'b000101;
                        5: cur_op = 6'b001000;
                        6: cur_op = 6'b000010;
                        7: cur_op = 6'b111111;
                        default: cur_op = 6'($urandom);
                    endcase
                end
                applyStimulus(cur_op, 1'($urandom_range(0, 3) != 0), 1'b0);
            end
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multicycle MIPS control unit: a Moore-style FSM that sequences each instruction through fetch, decode, execute, memory and writeback cycles, driving the shared-ALU/shared-memory multicycle datapath. It is the successor to the single-cycle main decoder and handles the same instruction set: R-type, LW, SW, BEQ, ADDI and J. It adds a memory-ready handshake, a wait-timeout error trap, illegal-opcode reporting and optional BNE.

## Interface
- TIMEOUT_MAX, 15: number of consecutive mem_ready=0 cycles tolerated in one wait state; 0 disables the timeout.
- TIMEOUT_W, 4: width of the wait counter; must satisfy 2^TIMEOUT_W > TIMEOUT_MAX.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- op  in  6  instr[31:26], taken from the instruction register; stable from DECODE onward.
- mem_ready  in  1  memory completes the current access in this cycle.
- mem_req  out  1  memory access request.
- iord  out  1  address select: 0 = PC, 1 = ALUOut.
- memwrite  out  1  memory write strobe.
- irwrite  out  1  instruction register load.
- pcwrite  out  1  unconditional PC load.
- branch  out  1  BEQ: PC load if zero.
- branch_ne  out  1  BNE: PC load if not zero.
- regdst  out  1  write register select: 0 = rt, 1 = rd.
- memtoreg  out  1  write data select: 0 = ALUOut, 1 = MDR.
- regwrite  out  1  register file write.
- alusrca  out  1  ALU A select: 0 = PC, 1 = rs.
- alusrcb  out  2  ALU B select: 00 = rt, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- aluop  out  2  to aludec: 00 = add, 01 = sub, 10 = funct, 11 = addi.
- pcsrc  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- illegal  out  1  one-cycle pulse on an unknown opcode.
- mem_err  out  1  sticky memory timeout flag.
- state  out  4  current state encoding, for debug.

## Operation
Any output not listed for a state is 0.

States, their encodings and outputs:
- FETCH (0): mem_req=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00.
  - irwrite and pcwrite are asserted only in the cycle where mem_ready=1.
- DECODE (1): alusrca=0, alusrcb=11, aluop=00. Latches is_bne from op.
- MEMADR (2): alusrca=1, alusrcb=10, aluop=00.
- MEMRD (3): mem_req=1, iord=1.
- MEMWB (4): memtoreg=1, regwrite=1, regdst=0.
- MEMWR (5): mem_req=1, iord=1, memwrite=1, held until mem_ready.
- EXECUTE (6): alusrca=1, alusrcb=00, aluop=10.
- ALUWB (7): regdst=1, regwrite=1.
- BRANCH (8): alusrca=1, alusrcb=00, aluop=01, pcsrc=01.
  - branch = ~is_bne, branch_ne = is_bne.
- ADDIEX (9): alusrca=1, alusrcb=10, aluop=11.
- ADDIWB (10): regwrite=1, regdst=0.
- JUMP (11): pcsrc=10, pcwrite=1.
- ERROR (12): mem_err=1; no further transitions.

Transitions:
- FETCH→DECODE on mem_ready; otherwise stay.
- DECODE dispatches on op:
  - 000000 → EXECUTE
  - 100011 / 101011 → MEMADR
  - 000100 (and 000101 when BNE is enabled) → BRANCH
  - 001000 → ADDIEX
  - 000010 → JUMP
  - any other op → FETCH, with illegal=1 in the DECODE cycle.
- MEMADR→MEMRD for LW, →MEMWR for SW.
- MEMRD→MEMWB on mem_ready.
- MEMWR→FETCH on mem_ready.
- EXECUTE→ALUWB; ADDIEX→ADDIWB.
- MEMWB, ALUWB, ADDIWB, BRANCH and JUMP all → FETCH.

Wait timer:
- Active in FETCH, MEMRD and MEMWR.
- Cleared on every state change.
- Increments in each wait-state cycle with mem_ready=0.
- When it already equals TIMEOUT_MAX and mem_ready=0 again, the next state is ERROR.
- mem_ready=1 in that same cycle wins: normal transition, no error.

## Timing
- Reset: state=FETCH, counter=0, is_bne=0, mem_err=0.
  - All outputs take their FETCH values; irwrite/pcwrite remain gated by mem_ready.
- rst=1 mid-instruction forces FETCH on the next edge; in-flight writes are abandoned.
- Cycles per instruction with zero wait:
  - LW: 5
  - SW, R-type, ADDI: 4
  - BEQ/BNE, J: 3
  - illegal: 2
- Each wait cycle adds 1.
- Outputs are combinational from state. irwrite/pcwrite in FETCH are additionally combinational from mem_ready.

## Configuration
- MC_BNE_EN defined: opcode 000101 decodes to BRANCH with is_bne=1, and branch_ne is driven.
- MC_BNE_EN undefined: 000101 is illegal, and branch_ne is tied to 0.

## Structure
- Package mc_pkg holds:
  - the state enum, 4 bits, with the encodings above
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J
  - aluop, alusrcb and pcsrc codes.
- One sub-module, mc_wait_timer: the clear/increment counter with TIMEOUT_MAX compare, producing timeout_hit.

## Test plan
- Reset, then op=100011 with mem_ready always 1 → state sequence 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in cycle 5.
- op=101011, mem_ready low for 3 cycles in MEMWR → memwrite high for 4 cycles; SW takes 7 cycles in total.
- op=000100, then op=000101 with MC_BNE_EN defined and undefined → branch=1 in BEQ's cycle 3. With the macro defined, branch_ne=1 in BNE's cycle 3; without it, illegal pulses in BNE's cycle 2 and the FSM returns to FETCH.
- op=111111 → illegal=1 for exactly one cycle in DECODE; no regwrite, memwrite or pcwrite in that instruction.
- TIMEOUT_MAX=3, mem_ready held 0 in FETCH → ERROR entered after 4 wait cycles; mem_err stays 1 until rst, and after rst the FSM is back in FETCH.
- mem_ready rises exactly on the timeout-hit cycle → normal FETCH→DECODE transition, mem_err stays 0.
